// File: rtl/io_uart_8085_if.sv
// 8085 bus control strobes (ALE/RDn/WRn/IOMn) shared by the CPU and the I/O-mapped peripherals.
interface io_uart_8085_if;
    logic ALE;
    logic RDn;
    logic WRn;
    logic IOMn;

    modport master (output ALE, output RDn, output WRn, output IOMn);
    modport slave  (input  ALE, input  RDn, input  WRn, input  IOMn);
endinterface

// File: rtl/io_uart_8085.sv
// I/O-mapped 8N1 UART on the 8085 multiplexed AD bus: 4-port window, TX/RX holding registers, bit divisor.
// Optional interrupt request output and enable register are built when UART_INTR_EN is defined.
module io_uart_8085 #(
    parameter logic [7:0]  BASE_ADDR   = 8'h20,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic           clk,
    input  logic           rst,
    io_uart_8085_if.slave  bus,
    inout  wire  [7:0]     AD,
    output logic           TXD,
    input  logic           RXD
`ifdef UART_INTR_EN
    ,
    output logic           INTR
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]  addr;
    logic        wrn_q, rdn_q;
    logic        sel, wr_stb, rd_stb;
    logic        wr_tx, wr_clr, rx_read;
    logic [15:0] div;
    logic [7:0]  rd_data;
    logic [7:0]  status;
    logic [1:0]  ien_bits;

    logic        tx_full;
    logic [7:0]  tx_hold;
    state_t      tx_state, tx_next;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bitn;
    logic [15:0] tx_cnt, tx_len;
    logic        tx_bit_end, tx_load;

    logic        rxd_p0, rxd_p1, rxd_p2;
    state_t      rx_state, rx_next;
    logic [7:0]  rx_shift, rx_data;
    logic [2:0]  rx_bitn;
    logic [15:0] rx_cnt, rx_len;
    logic [16:0] rx_half;
    logic        rx_fall, rx_mid, rx_bit_end, rx_load;
    logic        rx_rdy, ovr, fe;

    // Bus side: address latch and strobe edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr  <= 8'h00;
            wrn_q <= 1'b1;
            rdn_q <= 1'b1;
        end else begin
            if (bus.ALE) addr <= AD;
            wrn_q <= bus.WRn;
            rdn_q <= bus.RDn;
        end
    end

    assign sel     = bus.IOMn && (addr[7:2] == BASE_ADDR[7:2]);
    assign wr_stb  = sel && !wrn_q && bus.WRn;
    assign rd_stb  = sel && !rdn_q && bus.RDn;
    assign wr_tx   = wr_stb && (addr[1:0] == 2'd0);
    assign wr_clr  = wr_stb && (addr[1:0] == 2'd1) && AD[7];
    assign rx_read = rd_stb && (addr[1:0] == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= DEFAULT_DIV;
        end else if (wr_stb) begin
            if (addr[1:0] == 2'd2) div[7:0]  <= AD;
            if (addr[1:0] == 2'd3) div[15:8] <= AD;
        end
    end

    assign status = {1'b0, ien_bits, (tx_state != S_IDLE), fe, ovr, rx_rdy, !tx_full};

    always_comb begin
        rd_data = 8'h00;
        case (addr[1:0])
            2'd0: rd_data = rx_data;
            2'd1: rd_data = status;
            2'd2: rd_data = div[7:0];
            2'd3: rd_data = div[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    assign AD = (sel && !bus.RDn) ? rd_data : 8'hzz;

    // Transmitter: holding register feeding the shift FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         tx_full <= 1'b0;
        else if (wr_tx)   tx_full <= 1'b1;
        else if (tx_load) tx_full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_tx) tx_hold <= AD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= S_IDLE;
        else      tx_state <= tx_next;
    end

    assign tx_bit_end = (tx_cnt == tx_len);

    always_comb begin
        tx_next = tx_state;
        TXD     = 1'b1;
        case (tx_state)
            S_IDLE:  if (tx_full) tx_next = S_START;
            S_START: begin
                TXD = 1'b0;
                if (tx_bit_end) tx_next = S_DATA;
            end
            S_DATA: begin
                TXD = tx_shift[0];
                if (tx_bit_end && (tx_bitn == 3'd7)) tx_next = S_STOP;
            end
            S_STOP:  if (tx_bit_end) tx_next = tx_full ? S_START : S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    // A new frame starts whenever START is entered from IDLE or straight from STOP
    assign tx_load = (tx_next == S_START) && (tx_state != S_START);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt  <= 16'd0;
            tx_len  <= 16'd0;
            tx_bitn <= 3'd0;
        end else if (tx_load) begin
            tx_cnt  <= 16'd0;
            tx_len  <= div;
            tx_bitn <= 3'd0;
        end else if (tx_state != S_IDLE) begin
            if (tx_bit_end) begin
                tx_cnt <= 16'd0;
                tx_len <= div;
                if (tx_state == S_DATA) tx_bitn <= tx_bitn + 3'd1;
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_load)                             tx_shift <= tx_hold;
        else if (tx_state == S_DATA && tx_bit_end) tx_shift <= {1'b0, tx_shift[7:1]};
    end

    // Receiver: RXD synchroniser, then mid-bit sampling FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= RXD;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    assign rx_fall    = rxd_p2 && !rxd_p1;
    assign rx_half    = ({1'b0, rx_len} + 17'd1) >> 1;
    assign rx_mid     = ({1'b0, rx_cnt} == rx_half);
    assign rx_bit_end = (rx_cnt == rx_len);
    assign rx_load    = (rx_state == S_STOP) && rx_mid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= S_IDLE;
        else      rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: begin
                if (rx_mid && rxd_p1) rx_next = S_IDLE;
                else if (rx_bit_end)  rx_next = S_DATA;
            end
            S_DATA:  if (rx_bit_end && (rx_bitn == 3'd7)) rx_next = S_STOP;
            S_STOP:  if (rx_mid) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt  <= 16'd0;
            rx_len  <= 16'd0;
            rx_bitn <= 3'd0;
        end else if (rx_state == S_IDLE) begin
            rx_cnt  <= 16'd0;
            rx_len  <= div;
            rx_bitn <= 3'd0;
        end else if (rx_bit_end) begin
            rx_cnt <= 16'd0;
            rx_len <= div;
            if (rx_state == S_DATA) rx_bitn <= rx_bitn + 3'd1;
        end else begin
            rx_cnt <= rx_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_mid) rx_shift <= {rxd_p1, rx_shift[7:1]};
        if (rx_load)                      rx_data  <= rx_shift;
    end

    // A load on the same edge as a completing data read keeps RXRDY set without flagging overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_rdy <= 1'b0;
            ovr    <= 1'b0;
            fe     <= 1'b0;
        end else begin
            if (rx_load)      rx_rdy <= 1'b1;
            else if (rx_read) rx_rdy <= 1'b0;

            if (rx_load && rx_rdy && !rx_read) ovr <= 1'b1;
            else if (wr_clr)                   ovr <= 1'b0;

            if (rx_load && !rxd_p1) fe <= 1'b1;
            else if (wr_clr)        fe <= 1'b0;
        end
    end

`ifdef UART_INTR_EN
    logic [1:0] ien;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ien  <= 2'b00;
            INTR <= 1'b0;
        end else begin
            if (wr_stb && (addr[1:0] == 2'd1) && !AD[7]) ien <= AD[1:0];
            INTR <= (!tx_full && ien[0]) || (rx_rdy && ien[1]);
        end
    end

    assign ien_bits = ien;
`else
    assign ien_bits = 2'b00;
`endif

endmodule

// File: tb/tb_io_uart_8085.sv
// Directed bench for io_uart_8085: frame-level UART model plus per-cycle TXD comparison.
module tb_io_uart_8085;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       RXD;
    logic       TXD;
    logic [7:0] tb_ad = 8'h00;
    logic       tb_oe = 1'b0;
    wire  [7:0] AD;
`ifdef UART_INTR_EN
    logic       INTR;
`endif

    io_uart_8085_if bus();

    assign AD  = tb_oe ? tb_ad : 8'hzz;
    assign RXD = loop_en ? TXD : rxd_drv;

    always #5 clk = ~clk;

    io_uart_8085 dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .AD   (AD),
        .TXD  (TXD),
        .RXD  (RXD)
`ifdef UART_INTR_EN
        ,
        .INTR (INTR)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [15:0] m_div;
    bit          m_full;
    logic [7:0]  m_hold;
    bit          m_q[$];
    logic [7:0]  m_rx;
    bit          m_rxrdy, m_ovr, m_fe;
    logic [1:0]  m_ien;
    bit          wr_pend = 1'b0;
    logic [7:0]  wr_addr, wr_data;
    bit          wr_iom;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_expand(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int j = 0; j <= int'(m_div); j++)
                m_q.push_back(fr[i]);
    endfunction

    function automatic void m_apply_write();
        if (wr_iom && wr_addr[7:2] == 6'h08) begin
            case (wr_addr[1:0])
                2'd0: begin m_hold = wr_data; m_full = 1'b1; end
                2'd1: begin
                    if (wr_data[7]) begin m_ovr = 1'b0; m_fe = 1'b0; end
`ifdef UART_INTR_EN
                    else m_ien = wr_data[1:0];
`endif
                end
                2'd2: m_div[7:0]  = wr_data;
                default: m_div[15:8] = wr_data;
            endcase
        end
    endfunction

    function automatic logic [7:0] m_reg(input logic [1:0] p);
        case (p)
            2'd0: return m_rx;
            2'd1: return {1'b0, m_ien, (m_q.size() > 0), m_fe, m_ovr, m_rxrdy, !m_full};
            2'd2: return m_div[7:0];
            default: return m_div[15:8];
        endcase
    endfunction

    task automatic m_rx_load(input logic [7:0] b, input bit stop_lvl);
        if (m_rxrdy) m_ovr = 1'b1;
        m_rx    = b;
        m_rxrdy = 1'b1;
        if (!stop_lvl) m_fe = 1'b1;
    endtask

    // Model advances one clock per edge: retire one line sample, start the next frame, then take writes
    always @(posedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_div   = 16'd15;
            m_full  = 1'b0;
            m_rxrdy = 1'b0;
            m_ovr   = 1'b0;
            m_fe    = 1'b0;
            m_ien   = 2'b00;
            wr_pend = 1'b0;
        end else begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (m_q.size() == 0 && m_full) begin
                m_expand(m_hold);
                m_full = 1'b0;
            end
            if (wr_pend) begin
                wr_pend = 1'b0;
                m_apply_write();
            end
        end
    end

    always @(negedge clk) begin
        if (rst) check("txd_line", {7'b0, TXD}, {7'b0, (m_q.size() > 0) ? m_q[0] : 1'b1});
    end

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input bit iom = 1'b1);
        @(negedge clk); bus.ALE = 1'b1; bus.IOMn = iom; tb_oe = 1'b1; tb_ad = a;
        @(negedge clk); bus.ALE = 1'b0; tb_ad = d; bus.WRn = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.WRn = 1'b1;
        wr_addr = a; wr_data = d; wr_iom = iom; wr_pend = 1'b1;
        @(negedge clk); tb_oe = 1'b0; bus.IOMn = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic [7:0] exp,
                           input bit iom = 1'b1);
        @(negedge clk); bus.ALE = 1'b1; bus.IOMn = iom; tb_oe = 1'b1; tb_ad = a;
        @(negedge clk); bus.ALE = 1'b0; tb_oe = 1'b0; bus.RDn = 1'b0;
        @(negedge clk); d = AD; exp = m_reg(a[1:0]); bus.RDn = 1'b1;
        @(negedge clk); bus.IOMn = 1'b0;
        if (iom && a == 8'h20) m_rxrdy = 1'b0;
    endtask

    // Read a port and check it against both the model and a hand-computed literal
    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] lit);
        logic [7:0] v, e;
        io_read(a, v, e);
        check({name, "_model"}, v, e);
        check({name, "_lit"}, v, lit);
    endtask

    task automatic rd_model(input string name, input logic [7:0] a);
        logic [7:0] v, e;
        io_read(a, v, e);
        check(name, v, e);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_lvl);
        logic [9:0] fr;
        fr = {stop_lvl, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = fr[i];
            repeat (16) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (24) @(negedge clk);
        m_rx_load(b, stop_lvl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_bits;
        logic [7:0] v, e;
        logic [7:0] st_ien;
        a5_bits = 10'b1101001010;
        bus.ALE = 1'b0; bus.RDn = 1'b1; bus.WRn = 1'b1; bus.IOMn = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_txd", {7'b0, TXD}, 8'h01);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rd_chk("rst_status", 8'h21, 8'h01);
        rd_chk("rst_div_lo", 8'h22, 8'h0F);
        rd_chk("rst_div_hi", 8'h23, 8'h00);

        // 8'hA5 at DIV=15: literal line levels sampled mid-bit, status just after the write
        io_write(8'h20, 8'hA5);
        fork
            begin
                for (int k = 1; k <= 161; k++) begin
                    @(negedge clk);
                    if (((k - 1) % 16 == 8) && ((k - 1) / 16 < 10))
                        check("a5_bit", {7'b0, TXD}, {7'b0, a5_bits[(k - 1) / 16]});
                    if (k == 161) check("a5_idle", {7'b0, TXD}, 8'h01);
                end
            end
            begin
                io_read(8'h21, v, e);
                check("a5_status_busy", v, 8'h11);
            end
        join
        rd_chk("a5_status_done", 8'h21, 8'h01);

        // Loopback of 8'h3C
        loop_en = 1'b1;
        io_write(8'h20, 8'h3C);
        repeat (200) @(negedge clk);
        loop_en = 1'b0;
        m_rx_load(8'h3C, 1'b1);
        rd_chk("loop_data", 8'h20, 8'h3C);
        rd_chk("loop_status", 8'h21, 8'h01);

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_chk("ovr_status", 8'h21, 8'h07);
        rd_chk("ovr_data", 8'h20, 8'h22);
        rd_chk("ovr_status_rd", 8'h21, 8'h05);
        io_write(8'h21, 8'h80);
        rd_chk("ovr_cleared", 8'h21, 8'h01);

        // Framing error
        send_rx(8'h55, 1'b0);
        rd_chk("fe_status", 8'h21, 8'h0B);
        rd_chk("fe_data", 8'h20, 8'h55);
        rd_chk("fe_status_rd", 8'h21, 8'h09);
        io_write(8'h21, 8'h80);
        rd_chk("fe_cleared", 8'h21, 8'h01);

        // Memory cycles and out-of-window I/O must not touch the UART
        io_read(8'h22, v, e, 1'b0);
        check("mem_rd_not_driven", {7'b0, (v == 8'h0F)}, 8'h00);
        io_write(8'h20, 8'hEE, 1'b0);
        io_write(8'h22, 8'h07, 1'b0);
        io_write(8'h24, 8'h07);
        io_write(8'h1E, 8'h07);
        rd_chk("mem_wr_div", 8'h22, 8'h0F);
        rd_chk("mem_wr_status", 8'h21, 8'h01);

        // DIV=3: back-to-back frames with the holding byte overwritten before it is taken
        io_write(8'h22, 8'h03);
        rd_chk("div3_lo", 8'h22, 8'h03);
        io_write(8'h20, 8'hC3);
        io_write(8'h20, 8'h5A);
        io_write(8'h20, 8'h96);
        repeat (100) @(negedge clk);
        rd_chk("b2b_status", 8'h21, 8'h01);
        io_write(8'h23, 8'h01);
        rd_chk("div_hi_rw", 8'h23, 8'h01);
        io_write(8'h23, 8'h00);
        io_write(8'h22, 8'h0F);
        rd_chk("div_restore", 8'h22, 8'h0F);

        // Interrupt enable (ignored without UART_INTR_EN)
        io_write(8'h21, 8'h02);
`ifdef UART_INTR_EN
        st_ien = 8'h40;
`else
        st_ien = 8'h00;
`endif
        rd_chk("ien_status", 8'h21, 8'h01 | st_ien);
        send_rx(8'h7E, 1'b1);
`ifdef UART_INTR_EN
        check("intr_rx", {7'b0, INTR}, 8'h01);
`endif
        rd_chk("ien_rx_status", 8'h21, 8'h03 | st_ien);
        rd_chk("ien_rx_data", 8'h20, 8'h7E);
        repeat (2) @(negedge clk);
`ifdef UART_INTR_EN
        check("intr_cleared", {7'b0, INTR}, 8'h00);
`endif

        // Asynchronous reset in the middle of a frame of zeros
        io_write(8'h20, 8'h00);
        repeat (40) @(negedge clk);
        check("pre_rst_txd", {7'b0, TXD}, 8'h00);
        rst = 1'b0;
        #1;
        check("mid_rst_txd", {7'b0, TXD}, 8'h01);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rd_chk("post_rst_status", 8'h21, 8'h01);
        rd_chk("post_rst_div", 8'h22, 8'h0F);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
